register_file: RTL and testbench

//  Parametrised multi-register storage for the single-cycle datapath: NUM_REGS words of DATA_WIDTH

---
 rtl/register_file_pkg.sv | 15 +
 rtl/regfile_cell.sv | 21 ++
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: widths, zero-register option, reset value and address legality.
package register_file_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_ZERO_REG   = 0;
  localparam logic RESET_BIT    = 1'b0;

  // An address is usable when it maps onto an implemented register that is not the hardwired zero.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs,
                                      input logic zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One storage word of the register file: async active-low reset, synchronous clear (priority) and load.
module regfile_cell
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= {DATA_WIDTH{RESET_BIT}};
    else if (clear) q <= {DATA_WIDTH{RESET_BIT}};
    else if (load)  q <= d;
  end

endmodule

// File: rtl/register_file.sv
// Multi-register storage: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear) onto the read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = (1 << ADDR_WIDTH),
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 load;
  logic                                write_ok;

  assign write_ok = we && addr_valid(32'(waddr), NUM_REGS, ZERO_REG != 0);

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      load[i] = write_ok && (waddr == ADDR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    regfile_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .load    (load[g]),
      .d       (wdata),
      .q       (regs[g])
    );
  end

  // Unmapped addresses and the hardwired zero register read as 0.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0]             raddr,
    input logic [NUM_REGS-1:0][DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    if (addr_valid(32'(raddr), NUM_REGS, ZERO_REG != 0)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (raddr == ADDR_WIDTH'(i)) r = stored[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so the ports stay at 0 while reset_n is low.
    if (reset_n && clear)                           r = '0;
    else if (reset_n && write_ok && waddr == raddr) r = wdata;
`endif
    return r;
  endfunction

  assign rdata_a = read_port(raddr_a, regs);
  assign rdata_b = read_port(raddr_b, regs);

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default 8x8 instance plus a ZERO_REG=1, NUM_REGS=6 instance.
module tb_register_file;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear, we;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, rdata_a, rdata_b;

  logic       z_clear, z_we;
  logic [2:0] z_waddr, z_raddr_a, z_raddr_b;
  logic [7:0] z_wdata, z_rdata_a, z_rdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  register_file #(.NUM_REGS(6), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset_n(reset_n), .clear(z_clear), .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
    .raddr_a(z_raddr_a), .rdata_a(z_rdata_a), .raddr_b(z_raddr_b), .rdata_b(z_rdata_b)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_v;

  initial begin
    reset_n = 1'b0; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    z_clear = 1'b0; z_we = 1'b0; z_waddr = '0; z_wdata = '0; z_raddr_a = '0; z_raddr_b = '0;
    #2;
    raddr_a = 3'd3; raddr_b = 3'd7; #1;
    check_val("reset_a", rdata_a, 8'h00);
    check_val("reset_b", rdata_b, 8'h00);
    tick(); tick();
    reset_n = 1'b1;

    // r5 = 0x3C, read on both ports
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C; raddr_a = 3'd5; raddr_b = 3'd5; #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 8'h3C;
`else
    exp_v = 8'h00;
`endif
    check_val("wr5_same_cycle", rdata_a, exp_v);
    tick();
    we = 1'b0; #1;
    check_val("wr5_a", rdata_a, 8'h3C);
    check_val("wr5_b", rdata_b, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) begin
        raddr_a = 3'(i); #1;
        check_val($sformatf("wr5_other_r%0d", i), rdata_a, 8'h00);
      end
    end

    // back-to-back writes
    we = 1'b1; waddr = 3'd1; wdata = 8'h01; tick();
    wdata = 8'h02; tick();
    waddr = 3'd2; wdata = 8'h03; tick();
    we = 1'b0; raddr_a = 3'd1; raddr_b = 3'd2; #1;
    check_val("b2b_r1", rdata_a, 8'h02);
    check_val("b2b_r2", rdata_b, 8'h03);
    raddr_a = 3'd5; #1;
    check_val("b2b_r5_kept", rdata_a, 8'h3C);

    // same-cycle read of the write address
    we = 1'b1; waddr = 3'd4; wdata = 8'h11; tick();
    wdata = 8'h22; raddr_a = 3'd4; #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 8'h22;
`else
    exp_v = 8'h11;
`endif
    check_val("r4_write_cycle", rdata_a, exp_v);
    tick();
    we = 1'b0; #1;
    check_val("r4_after", rdata_a, 8'h22);

    // clear beats a simultaneous write
    clear = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'hFF; raddr_a = 3'd2; #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 8'h00;
`else
    exp_v = 8'h03;
`endif
    check_val("clear_cycle_r2", rdata_a, exp_v);
    tick();
    clear = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_b = 3'(i); #1;
      check_val($sformatf("cleared_r%0d", i), rdata_b, 8'h00);
    end

    // async reset mid-cycle, then release mid-cycle with a pending write
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5; tick();
    we = 1'b0; raddr_a = 3'd3; #1;
    check_val("r3_written", rdata_a, 8'hA5);
    #1 reset_n = 1'b0; #1;
    check_val("r3_async_reset", rdata_a, 8'h00);
    we = 1'b1; waddr = 3'd6; wdata = 8'h5A; raddr_a = 3'd6; #1;
    check_val("reset_bypass_blocked", rdata_a, 8'h00);
    tick();
    check_val("r6_write_in_reset", rdata_a, 8'h00);
    #2 reset_n = 1'b1;
    tick();
    we = 1'b0; #1;
    check_val("r6_after_release", rdata_a, 8'h5A);

    // zero register and out-of-range on the 6-register instance
    z_we = 1'b1; z_waddr = 3'd5; z_wdata = 8'h55; tick();
    z_waddr = 3'd0; z_wdata = 8'h77; z_raddr_a = 3'd0; #1;
    check_val("z_r0_write_cycle", z_rdata_a, 8'h00);
    tick();
    z_waddr = 3'd7; z_wdata = 8'h99; z_raddr_b = 3'd7; #1;
    check_val("z_r7_write_cycle", z_rdata_b, 8'h00);
    tick();
    z_we = 1'b0; #1;
    check_val("z_r0", z_rdata_a, 8'h00);
    check_val("z_r7", z_rdata_b, 8'h00);
    z_raddr_b = 3'd6; #1;
    check_val("z_r6", z_rdata_b, 8'h00);
    for (int i = 1; i < 6; i++) begin
      z_raddr_a = 3'(i); #1;
      check_val($sformatf("z_r%0d", i), z_rdata_a, (i == 5) ? 8'h55 : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
